// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor
// Independent safety monitor sitting between the traffic-light controller
// and the lamp drivers. Both 2-bit light codes (00 Red, 01 Yellow,
// 11 Green, 10 illegal) pass through a two-stage register pipeline. Each
// check compares the newest sample (q) against the previous one (prev).
// On the first violation the monitor:
//   - latches a sticky fault,
//   - records the lowest-numbered cause in fault_code,
//   - forces both lamp outputs to Red,
//   - runs a flashing beacon.
// Only clear leaves the fault state.
//
// Optional feature macro: SIGNAL_MONITOR_GRN_MIN_CHECK_EN
//   When defined, a G->Y move with green dwell < GRN_MIN raises fault code 6.
//   When undefined, code 6 is never produced.

module signal_conflict_monitor #(
    parameter int YEL_MIN    = 3,
    parameter int GRN_MIN    = 7,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] country,
    output logic [1:0] hwy_out,
    output logic [1:0] country_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_ILL = 2'b10;
    localparam logic [1:0] C_GRN = 2'b11;

    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] YEL_MIN_C = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] GRN_MIN_C = CNT_W'(GRN_MIN);

    localparam int FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);

`ifdef SIGNAL_MONITOR_GRN_MIN_CHECK_EN
    localparam bit GRN_CHK_EN = 1'b1;
`else
    localparam bit GRN_CHK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_hwy_q;
    logic [1:0]        r_cty_q;
    logic [1:0]        r_hwy_prev;
    logic [1:0]        r_cty_prev;
    logic [CNT_W-1:0]  r_hwy_dwell;
    logic [CNT_W-1:0]  r_cty_dwell;
    logic              r_fault;
    logic [2:0]        r_code;
    logic              r_flash;
    logic [FL_W-1:0]   r_flash_cnt;

    logic              w_conflict;
    logic              w_illegal;
    logic              w_bad_hwy;
    logic              w_bad_cty;
    logic              w_short_yel;
    logic              w_short_grn;
    logic [2:0]        w_code;

    // Legal moves: hold, R->G, G->Y, Y->R.
    function automatic logic legal_move(input logic [1:0] old_c, input logic [1:0] new_c);
        legal_move = (new_c == old_c) ||
                     (old_c == C_RED && new_c == C_GRN) ||
                     (old_c == C_GRN && new_c == C_YEL) ||
                     (old_c == C_YEL && new_c == C_RED);
    endfunction

    // Violation detection with lowest-code priority. Transition and dwell
    // checks only apply in RUN, because in INIT prev is not yet meaningful.
    always_comb begin
        w_conflict  = (r_hwy_q != C_RED) && (r_cty_q != C_RED);
        w_illegal   = (r_hwy_q == C_ILL) || (r_cty_q == C_ILL);
        w_bad_hwy   = !legal_move(r_hwy_prev, r_hwy_q);
        w_bad_cty   = !legal_move(r_cty_prev, r_cty_q);
        w_short_yel = (r_hwy_prev == C_YEL && r_hwy_q == C_RED && r_hwy_dwell < YEL_MIN_C) ||
                      (r_cty_prev == C_YEL && r_cty_q == C_RED && r_cty_dwell < YEL_MIN_C);
        w_short_grn = (r_hwy_prev == C_GRN && r_hwy_q == C_YEL && r_hwy_dwell < GRN_MIN_C) ||
                      (r_cty_prev == C_GRN && r_cty_q == C_YEL && r_cty_dwell < GRN_MIN_C);
        w_code      = 3'd0;
        if (w_conflict) begin
            w_code = 3'd1;
        end else if (w_illegal) begin
            w_code = 3'd2;
        end else if (r_state == ST_RUN) begin
            if (w_bad_hwy) begin
                w_code = 3'd3;
            end else if (w_bad_cty) begin
                w_code = 3'd4;
            end else if (w_short_yel) begin
                w_code = 3'd5;
            end else if (GRN_CHK_EN && w_short_grn) begin
                w_code = 3'd6;
            end
        end
    end

    // Two-stage sample pipeline plus per-channel dwell counters.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_hwy_q     <= C_RED;
            r_cty_q     <= C_RED;
            r_hwy_prev  <= C_RED;
            r_cty_prev  <= C_RED;
            r_hwy_dwell <= '0;
            r_cty_dwell <= '0;
        end else begin
            r_hwy_q    <= hwy;
            r_cty_q    <= country;
            r_hwy_prev <= r_hwy_q;
            r_cty_prev <= r_cty_q;
            if (r_hwy_q != r_hwy_prev) begin
                r_hwy_dwell <= CNT_W'(1);
            end else if (r_hwy_dwell != DWELL_MAX) begin
                r_hwy_dwell <= r_hwy_dwell + CNT_W'(1);
            end
            if (r_cty_q != r_cty_prev) begin
                r_cty_dwell <= CNT_W'(1);
            end else if (r_cty_dwell != DWELL_MAX) begin
                r_cty_dwell <= r_cty_dwell + CNT_W'(1);
            end
        end
    end

    // Monitor FSM: sticky fault, first-cause latch and beacon counter.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= ST_INIT;
            r_fault     <= 1'b0;
            r_code      <= 3'd0;
            r_flash     <= 1'b0;
            r_flash_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT, ST_RUN: begin
                    if (w_code != 3'd0) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                        r_code  <= w_code;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FAULT: begin
                    if (r_flash_cnt == FL_LAST) begin
                        r_flash_cnt <= '0;
                        r_flash     <= ~r_flash;
                    end else begin
                        r_flash_cnt <= r_flash_cnt + FL_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Lamp drive: prev and fault load on the same edge, so an offending
    // pattern is masked before it can reach the lamps.
    assign hwy_out     = r_fault ? C_RED : r_hwy_prev;
    assign country_out = r_fault ? C_RED : r_cty_prev;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign flash       = r_flash;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// tb_signal_conflict_monitor
// Directed scenarios plus randomized traffic for signal_conflict_monitor.
// The reference model keeps the history of sampled light codes since the
// last clear. It derives each expected output from that history:
//   - dwell is the run length found by scanning the history backwards,
//   - the flash phase is computed from the elapsed time since the fault.

module tb_signal_conflict_monitor;

    localparam int YEL_MIN    = 3;
    localparam int GRN_MIN    = 7;
    localparam int FLASH_HALF = 4;
    localparam int CNT_W      = 4;
    localparam int SAT        = (1 << CNT_W) - 1;
    localparam int HMAX       = 4096;

    logic       clock = 1'b0;
    logic       clear;
    logic [1:0] hwy;
    logic [1:0] country;
    logic [1:0] hwy_out;
    logic [1:0] country_out;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;

    int n_vec = 0;
    int n_err = 0;

    // History of sampled codes since clear: hh[0]/hc[0] is the reset value.
    int hh [0:HMAX-1];
    int hc [0:HMAX-1];
    int n_hist = 0;
    bit m_fault = 1'b0;
    int m_code = 0;
    int m_frise = 0;
    logic [1:0] exp_h;
    logic [1:0] exp_c;
    logic       exp_flash;

    signal_conflict_monitor #(
        .YEL_MIN(YEL_MIN), .GRN_MIN(GRN_MIN), .FLASH_HALF(FLASH_HALF), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .clear(clear),
        .hwy(hwy),
        .country(country),
        .hwy_out(hwy_out),
        .country_out(country_out),
        .fault(fault),
        .fault_code(fault_code),
        .flash(flash)
    );

    // Clock generation.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit move_ok(input int o, input int n);
        return (n == o) || (o == 0 && n == 3) || (o == 3 && n == 1) || (o == 1 && n == 0);
    endfunction

    // Length of the run of equal values ending at idx, saturated.
    function automatic int run_len(input bit is_h, input int idx);
        int v;
        int len;
        v = is_h ? hh[idx] : hc[idx];
        len = 0;
        for (int k = idx; k >= 0; k--) begin
            if ((is_h ? hh[k] : hc[k]) != v) break;
            len++;
        end
        return (len > SAT) ? SAT : len;
    endfunction

    // Advance the model by one clock edge with the given inputs applied.
    task automatic model_edge(input bit clr, input logic [1:0] h, input logic [1:0] c);
        int i;
        int nh;
        int nc;
        int oh;
        int oc;
        int code;
        int dh;
        int dc;
        if (clr) begin
            hh[0] = 0;
            hc[0] = 0;
            n_hist = 1;
            m_fault = 1'b0;
            m_code = 0;
            exp_h = 2'b00;
            exp_c = 2'b00;
            exp_flash = 1'b0;
        end else begin
            i  = n_hist;
            nh = hh[i-1];
            nc = hc[i-1];
            oh = (i >= 2) ? hh[i-2] : 0;
            oc = (i >= 2) ? hc[i-2] : 0;
            if (!m_fault) begin
                code = 0;
                if (nh != 0 && nc != 0) begin
                    code = 1;
                end else if (nh == 2 || nc == 2) begin
                    code = 2;
                end else if (i >= 2) begin
                    dh = run_len(1'b1, i - 2);
                    dc = run_len(1'b0, i - 2);
                    if (!move_ok(oh, nh)) begin
                        code = 3;
                    end else if (!move_ok(oc, nc)) begin
                        code = 4;
                    end else if ((oh == 1 && nh == 0 && dh < YEL_MIN) ||
                                 (oc == 1 && nc == 0 && dc < YEL_MIN)) begin
                        code = 5;
`ifdef SIGNAL_MONITOR_GRN_MIN_CHECK_EN
                    end else if ((oh == 3 && nh == 1 && dh < GRN_MIN) ||
                                 (oc == 3 && nc == 1 && dc < GRN_MIN)) begin
                        code = 6;
`endif
                    end
                end
                if (code != 0) begin
                    m_fault = 1'b1;
                    m_code  = code;
                    m_frise = i;
                end
            end
            if (n_hist < HMAX) begin
                hh[n_hist] = int'(h);
                hc[n_hist] = int'(c);
                n_hist++;
            end
            exp_h = m_fault ? 2'b00 : 2'(nh);
            exp_c = m_fault ? 2'b00 : 2'(nc);
            exp_flash = m_fault && ((((i - m_frise) / FLASH_HALF) % 2) == 1);
        end
    endtask

    // Driver: apply one vector, advance one edge, compare all outputs.
    task automatic step(input bit clr, input logic [1:0] h, input logic [1:0] c);
        @(negedge clock);
        clear   = clr;
        hwy     = h;
        country = c;
        model_edge(clr, h, c);
        @(posedge clock);
        #1;
        check_eq("hwy_out", {6'd0, hwy_out}, {6'd0, exp_h});
        check_eq("country_out", {6'd0, country_out}, {6'd0, exp_c});
        check_eq("fault", {7'd0, fault}, {7'd0, m_fault});
        check_eq("fault_code", {5'd0, fault_code}, 8'(m_code));
        check_eq("flash", {7'd0, flash}, {7'd0, exp_flash});
    endtask

    task automatic hold(input logic [1:0] h, input logic [1:0] c, input int n);
        for (int k = 0; k < n; k++) step(1'b0, h, c);
    endtask

    // Randomized traffic cycling with random phase lengths and glitches.
    task automatic random_round();
        int g;
        int y;
        int r;
        bit on_h;
        on_h = 1'b1;
        step(1'b1, 2'b00, 2'b00);
        for (int p = 0; p < 4; p++) begin
            g = int'($urandom_range(1, 10));
            y = int'($urandom_range(1, 5));
            r = int'($urandom_range(0, 2));
            if (on_h) begin
                hold(2'b11, 2'b00, g);
                hold(2'b01, 2'b00, y);
            end else begin
                hold(2'b00, 2'b11, g);
                hold(2'b00, 2'b01, y);
            end
            hold(2'b00, 2'b00, r);
            if ($urandom_range(0, 7) == 0) begin
                step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
            on_h = !on_h;
        end
    endtask

    initial begin
        clear   = 1'b1;
        hwy     = 2'b00;
        country = 2'b00;

        // Normal cycle
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00);
        hold(2'b11, 2'b00, 10);
        hold(2'b01, 2'b00, 4);
        hold(2'b00, 2'b11, 10);
        hold(2'b00, 2'b01, 4);
        hold(2'b11, 2'b00, 4);
        check_eq("normal_fault", {7'd0, fault}, 8'd0);
        check_eq("normal_out", {6'd0, hwy_out}, 8'd3);

        // Conflict, then watch the beacon
        step(1'b1, 2'b00, 2'b00);
        hold(2'b11, 2'b00, 3);
        hold(2'b11, 2'b11, 1);
        hold(2'b11, 2'b00, 1);
        check_eq("conflict_code", {5'd0, fault_code}, 8'd1);
        check_eq("conflict_out", {4'd0, hwy_out, country_out}, 8'd0);
        hold(2'b11, 2'b00, 12);

        // Illegal transition, later violation ignored
        step(1'b1, 2'b00, 2'b00);
        hold(2'b11, 2'b00, 3);
        hold(2'b00, 2'b00, 3);
        check_eq("illegal_trans", {5'd0, fault_code}, 8'd3);
        hold(2'b00, 2'b10, 2);
        check_eq("frozen_code", {5'd0, fault_code}, 8'd3);

        // Short yellow
        step(1'b1, 2'b00, 2'b00);
        hold(2'b11, 2'b00, 8);
        hold(2'b01, 2'b00, 2);
        hold(2'b00, 2'b00, 3);
        check_eq("short_yel", {5'd0, fault_code}, 8'd5);

        // Minimum legal yellow
        step(1'b1, 2'b00, 2'b00);
        hold(2'b11, 2'b00, 8);
        hold(2'b01, 2'b00, 3);
        hold(2'b00, 2'b00, 3);
        check_eq("min_yel", {7'd0, fault}, 8'd0);

        // Saturated green dwell then yellow
        hold(2'b11, 2'b00, 20);
        hold(2'b01, 2'b00, 3);
        hold(2'b00, 2'b00, 2);
        check_eq("sat_dwell", {7'd0, fault}, 8'd0);

        // Simultaneous violations, then clear while faulted
        step(1'b1, 2'b00, 2'b00);
        hold(2'b11, 2'b00, 2);
        hold(2'b10, 2'b11, 1);
        hold(2'b00, 2'b00, 2);
        check_eq("priority", {5'd0, fault_code}, 8'd1);
        step(1'b1, 2'b11, 2'b11);
        check_eq("clear_code", {5'd0, fault_code}, 8'd0);
        hold(2'b11, 2'b00, 4);

        // Short green: code 6 only with the optional check enabled
        step(1'b1, 2'b00, 2'b00);
        hold(2'b11, 2'b00, 5);
        hold(2'b01, 2'b00, 3);
`ifdef SIGNAL_MONITOR_GRN_MIN_CHECK_EN
        check_eq("short_grn", {5'd0, fault_code}, 8'd6);
`else
        check_eq("short_grn", {5'd0, fault_code}, 8'd0);
`endif

        for (int r = 0; r < 40; r++) random_round();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
